ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus operand-select/forwarding logic.
- Latches one decoded instruction from ID under a valid/allowin handshake.
- Resolves RAW hazards against the MEM and WB stages and drives src1, src2 and the 11-bit one-hot op directly into the ALU.
- Also carries PC, rd, write-enable, load flag and store data toward MEM.

---
 rtl/ex_operand_stage.sv | 182 ++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand select, MEM/WB forwarding and load-use stall.
// Define EX_FWD_EN to enable forwarding; when it is undefined, any MEM/WB hit on a used operand stalls.
module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int OP_W = 11
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            id_to_ex_valid,
  output logic            ex_allowin,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [OP_W-1:0] id_alu_op,
  input  logic            id_src1_is_pc,
  input  logic            id_src2_is_imm,
  input  logic            id_rf_we,
  input  logic            id_is_load,
  input  logic            mem_fwd_valid,
  input  logic            mem_fwd_we,
  input  logic            mem_fwd_is_load,
  input  logic [4:0]      mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_valid,
  input  logic            wb_fwd_we,
  input  logic [4:0]      wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  output logic [OP_W-1:0] alu_op,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic            ex_rf_we,
  output logic            ex_is_load,
  input  logic            mem_allowin,
  output logic            ex_to_mem_valid
);

  logic            ex_valid_r;
  logic [XLEN-1:0] pc_r, imm_r, rs1_data_r, rs2_data_r;
  logic [4:0]      rs1_r, rs2_r, rd_r;
  logic [OP_W-1:0] alu_op_r;
  logic            src1_is_pc_r, src2_is_imm_r, rf_we_r, is_load_r;

  logic            mem_hit1_s, mem_hit2_s, wb_hit1_s, wb_hit2_s;
  logic            use1_s, use2_s, stall_s, ex_ready_go_s;
  logic [XLEN-1:0] fwd1_s, fwd2_s;

  assign mem_hit1_s = mem_fwd_valid & mem_fwd_we & (mem_fwd_rd == rs1_r) & (rs1_r != 5'd0);
  assign mem_hit2_s = mem_fwd_valid & mem_fwd_we & (mem_fwd_rd == rs2_r) & (rs2_r != 5'd0);
  assign wb_hit1_s  = wb_fwd_valid & wb_fwd_we & (wb_fwd_rd == rs1_r) & (rs1_r != 5'd0);
  assign wb_hit2_s  = wb_fwd_valid & wb_fwd_we & (wb_fwd_rd == rs2_r) & (rs2_r != 5'd0);

  // A store (no rf write, not a load) consumes rs2 through ex_store_data even with an immediate src2
  assign use1_s = ~src1_is_pc_r;
  assign use2_s = ~src2_is_imm_r | (~rf_we_r & ~is_load_r);

`ifdef EX_FWD_EN
  // Forward mux (MEM beats WB); only a load in MEM cannot be bypassed yet
  always_comb begin
    fwd1_s = rs1_data_r;
    fwd2_s = rs2_data_r;
    if (mem_hit1_s) begin
      fwd1_s = mem_fwd_data;
    end else if (wb_hit1_s) begin
      fwd1_s = wb_fwd_data;
    end else begin
      fwd1_s = rs1_data_r;
    end
    if (mem_hit2_s) begin
      fwd2_s = mem_fwd_data;
    end else if (wb_hit2_s) begin
      fwd2_s = wb_fwd_data;
    end else begin
      fwd2_s = rs2_data_r;
    end
    stall_s = mem_fwd_is_load & ((mem_hit1_s & use1_s) | (mem_hit2_s & use2_s));
  end
`else
  // No bypass: any pending producer of a used operand stalls until it retires
  always_comb begin
    fwd1_s  = rs1_data_r;
    fwd2_s  = rs2_data_r;
    stall_s = ((mem_hit1_s | wb_hit1_s) & use1_s) | ((mem_hit2_s | wb_hit2_s) & use2_s);
  end

  logic fwd_unused_s;
  assign fwd_unused_s = ^{mem_fwd_data, wb_fwd_data, mem_fwd_is_load};
`endif

  assign ex_ready_go_s = ~stall_s;

  // Handshake and operand select; alu_op is gated so bubbles drive a zero ALU result
  always_comb begin
    ex_allowin      = ~ex_valid_r | (ex_ready_go_s & mem_allowin);
    ex_to_mem_valid = ex_valid_r & ex_ready_go_s;
    if (src1_is_pc_r) begin
      alu_src1 = pc_r;
    end else begin
      alu_src1 = fwd1_s;
    end
    if (src2_is_imm_r) begin
      alu_src2 = imm_r;
    end else begin
      alu_src2 = fwd2_s;
    end
    if (ex_valid_r) begin
      alu_op = alu_op_r;
    end else begin
      alu_op = {OP_W{1'b0}};
    end
    ex_store_data = fwd2_s;
    ex_pc         = pc_r;
    ex_rd         = rd_r;
    ex_rf_we      = rf_we_r;
    ex_is_load    = is_load_r;
  end

  // Valid bit: flush wins over a simultaneous accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid_r <= 1'b0;
    end else if (flush) begin
      ex_valid_r <= 1'b0;
    end else if (ex_allowin) begin
      ex_valid_r <= id_to_ex_valid;
    end else begin
      ex_valid_r <= ex_valid_r;
    end
  end

  // Payload loads on any accepted offer, even under flush, since valid is cleared anyway
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_r          <= {XLEN{1'b0}};
      imm_r         <= {XLEN{1'b0}};
      rs1_data_r    <= {XLEN{1'b0}};
      rs2_data_r    <= {XLEN{1'b0}};
      rs1_r         <= 5'd0;
      rs2_r         <= 5'd0;
      rd_r          <= 5'd0;
      alu_op_r      <= {OP_W{1'b0}};
      src1_is_pc_r  <= 1'b0;
      src2_is_imm_r <= 1'b0;
      rf_we_r       <= 1'b0;
      is_load_r     <= 1'b0;
    end else if (id_to_ex_valid && ex_allowin) begin
      pc_r          <= id_pc;
      imm_r         <= id_imm;
      rs1_data_r    <= id_rs1_data;
      rs2_data_r    <= id_rs2_data;
      rs1_r         <= id_rs1;
      rs2_r         <= id_rs2;
      rd_r          <= id_rd;
      alu_op_r      <= id_alu_op;
      src1_is_pc_r  <= id_src1_is_pc;
      src2_is_imm_r <= id_src2_is_imm;
      rf_we_r       <= id_rf_we;
      is_load_r     <= id_is_load;
    end else begin
      pc_r          <= pc_r;
      imm_r         <= imm_r;
      rs1_data_r    <= rs1_data_r;
      rs2_data_r    <= rs2_data_r;
      rs1_r         <= rs1_r;
      rs2_r         <= rs2_r;
      rd_r          <= rd_r;
      alu_op_r      <= alu_op_r;
      src1_is_pc_r  <= src1_is_pc_r;
      src2_is_imm_r <= src2_is_imm_r;
      rf_we_r       <= rf_we_r;
      is_load_r     <= is_load_r;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: expected outputs queued at issue, compared on ex_to_mem_valid & mem_allowin.
// Covers both builds; the EX_FWD_EN macro selects the forwarding or stall-only expectations.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        resetn, flush, id_to_ex_valid, ex_allowin;
  logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [10:0] id_alu_op;
  logic        id_src1_is_pc, id_src2_is_imm, id_rf_we, id_is_load;
  logic        mem_fwd_valid, mem_fwd_we, mem_fwd_is_load;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_valid, wb_fwd_we;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic [31:0] alu_src1, alu_src2, ex_store_data, ex_pc;
  logic [10:0] alu_op;
  logic [4:0]  ex_rd;
  logic        ex_rf_we, ex_is_load, mem_allowin, ex_to_mem_valid;

  typedef struct {
    logic [31:0] s1, s2, sd, pc;
    logic [10:0] op;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .resetn(resetn), .flush(flush), .id_to_ex_valid(id_to_ex_valid),
    .ex_allowin(ex_allowin), .id_pc(id_pc), .id_imm(id_imm), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_src1_is_pc(id_src1_is_pc), .id_src2_is_imm(id_src2_is_imm),
    .id_rf_we(id_rf_we), .id_is_load(id_is_load), .mem_fwd_valid(mem_fwd_valid),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_is_load(mem_fwd_is_load), .mem_fwd_rd(mem_fwd_rd),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_valid(wb_fwd_valid), .wb_fwd_we(wb_fwd_we),
    .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data), .alu_src1(alu_src1),
    .alu_src2(alu_src2), .alu_op(alu_op), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
    .mem_allowin(mem_allowin), .ex_to_mem_valid(ex_to_mem_valid)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, imm, r1d, r2d, input logic [4:0] r1, r2, rd,
                       input logic [10:0] op, input logic s1pc, s2imm, we, ld);
    id_pc = pc; id_imm = imm; id_rs1_data = r1d; id_rs2_data = r2d;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_alu_op = op;
    id_src1_is_pc = s1pc; id_src2_is_imm = s2imm; id_rf_we = we; id_is_load = ld;
    id_to_ex_valid = 1'b1;
  endtask

  task automatic push(input logic [31:0] s1, s2, sd, pc, input logic [10:0] op, input logic [4:0] rd);
    exp_t e;
    e.s1 = s1; e.s2 = s2; e.sd = sd; e.pc = pc; e.op = op; e.rd = rd;
    sb.push_back(e);
  endtask

  // Output monitor: every transfer to MEM must match the oldest queued expectation
  always @(negedge clk) begin
    if (resetn && ex_to_mem_valid && mem_allowin) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("out_src1", alu_src1, mon_e.s1);
        check("out_src2", alu_src2, mon_e.s2);
        check("out_store", ex_store_data, mon_e.sd);
        check("out_pc", ex_pc, mon_e.pc);
        check("out_op", {21'd0, alu_op}, {21'd0, mon_e.op});
        check("out_rd", {27'd0, ex_rd}, {27'd0, mon_e.rd});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; flush = 1'b0; id_to_ex_valid = 1'b0; mem_allowin = 1'b1;
    id_pc = 32'd0; id_imm = 32'd0; id_rs1_data = 32'd0; id_rs2_data = 32'd0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_alu_op = 11'd0;
    id_src1_is_pc = 1'b0; id_src2_is_imm = 1'b0; id_rf_we = 1'b0; id_is_load = 1'b0;
    mem_fwd_valid = 1'b0; mem_fwd_we = 1'b1; mem_fwd_is_load = 1'b0; mem_fwd_rd = 5'd0;
    mem_fwd_data = 32'd0; wb_fwd_valid = 1'b0; wb_fwd_we = 1'b1; wb_fwd_rd = 5'd0;
    wb_fwd_data = 32'd0;

    repeat (2) @(negedge clk);
    check("rst_allowin", {31'd0, ex_allowin}, 32'd1);
    check("rst_valid", {31'd0, ex_to_mem_valid}, 32'd0);
    check("rst_op", {21'd0, alu_op}, 32'd0);
    check("rst_src1", alu_src1, 32'd0);
    check("rst_pc", ex_pc, 32'd0);
    step();
    resetn = 1'b1;

    // Simple add: rs1 data + immediate
    push(32'd5, 32'd7, 32'd9, 32'h100, 11'h001, 5'd2);
    offer(32'h100, 32'd7, 32'd5, 32'd9, 5'd1, 5'd0, 5'd2, 11'h001, 1'b0, 1'b1, 1'b1, 1'b0);
    step(); id_to_ex_valid = 1'b0;
    @(negedge clk); check("add_go", {31'd0, ex_to_mem_valid}, 32'd1);
    step();

    // PC as src1
    push(32'h200, 32'h20, 32'h22, 32'h200, 11'h400, 5'd3);
    offer(32'h200, 32'h20, 32'h11, 32'h22, 5'd7, 5'd8, 5'd3, 11'h400, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); id_to_ex_valid = 1'b0;
    @(negedge clk); step();

    // Backpressure holds payload, then flush kills it
    mem_allowin = 1'b0;
    offer(32'h300, 32'd1, 32'h31, 32'h32, 5'd9, 5'd10, 5'd4, 11'h002, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    offer(32'h400, 32'd2, 32'h41, 32'h42, 5'd11, 5'd12, 5'd5, 11'h008, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("bp_go", {31'd0, ex_to_mem_valid}, 32'd1);
    check("bp_allowin", {31'd0, ex_allowin}, 32'd0);
    step();
    @(negedge clk);
    check("bp_pc_held", ex_pc, 32'h300);
    check("bp_src1_held", alu_src1, 32'h31);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; id_to_ex_valid = 1'b0; mem_allowin = 1'b1;
    @(negedge clk);
    check("flush_valid", {31'd0, ex_to_mem_valid}, 32'd0);
    check("flush_allowin", {31'd0, ex_allowin}, 32'd1);
    check("flush_op", {21'd0, alu_op}, 32'd0);
    step();

    // Flush beats an accept into an empty EX; payload still loads
    flush = 1'b1;
    offer(32'h440, 32'd2, 32'h41, 32'h42, 5'd11, 5'd12, 5'd5, 11'h008, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    flush = 1'b0; id_to_ex_valid = 1'b0;
    @(negedge clk);
    check("flush_empty_valid", {31'd0, ex_to_mem_valid}, 32'd0);
    check("flush_empty_pc", ex_pc, 32'h440);
    step();

    // Load-use on rs2: stall while the load sits in MEM
    offer(32'h500, 32'd0, 32'd0, 32'h77, 5'd0, 5'd5, 5'd6, 11'h001, 1'b0, 1'b0, 1'b1, 1'b0);
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_is_load = 1'b1; mem_fwd_data = 32'hDEAD;
    step(); id_to_ex_valid = 1'b0;
    @(negedge clk);
    check("lu_go", {31'd0, ex_to_mem_valid}, 32'd0);
    check("lu_allowin", {31'd0, ex_allowin}, 32'd0);
    step();
    mem_fwd_valid = 1'b0; mem_fwd_is_load = 1'b0;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'h1234;
`ifdef EX_FWD_EN
    push(32'd0, 32'h1234, 32'h1234, 32'h500, 11'h001, 5'd6);
    @(negedge clk); check("lu_wb_go", {31'd0, ex_to_mem_valid}, 32'd1);
    step(); wb_fwd_valid = 1'b0;
`else
    @(negedge clk); check("lu_wb_stall", {31'd0, ex_to_mem_valid}, 32'd0);
    step(); wb_fwd_valid = 1'b0;
    push(32'd0, 32'h77, 32'h77, 32'h500, 11'h001, 5'd6);
    @(negedge clk); check("lu_rf_go", {31'd0, ex_to_mem_valid}, 32'd1);
    step();
`endif

    // Reset during a stall discards everything, no output pulse
    offer(32'h580, 32'd0, 32'h66, 32'd0, 5'd3, 5'd0, 5'd6, 11'h010, 1'b0, 1'b1, 1'b1, 1'b0);
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_is_load = 1'b1;
    step(); id_to_ex_valid = 1'b0;
    @(negedge clk); check("rm_stall", {31'd0, ex_to_mem_valid}, 32'd0);
    #2 resetn = 1'b0;
    #1;
    check("rm_go", {31'd0, ex_to_mem_valid}, 32'd0);
    check("rm_pc", ex_pc, 32'd0);
    check("rm_allowin", {31'd0, ex_allowin}, 32'd1);
    mem_fwd_valid = 1'b0; mem_fwd_is_load = 1'b0;
    step(); resetn = 1'b1;
    @(negedge clk); check("rm_after", {31'd0, ex_to_mem_valid}, 32'd0);
    step();

`ifdef EX_FWD_EN
    // MEM beats WB, WB used when MEM idle, x0 never forwarded
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'hAA;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd3; wb_fwd_data = 32'hBB;
    push(32'hAA, 32'd1, 32'd0, 32'h600, 11'h001, 5'd1);
    offer(32'h600, 32'd1, 32'h33, 32'd0, 5'd3, 5'd0, 5'd1, 11'h001, 1'b0, 1'b1, 1'b1, 1'b0);
    step(); id_to_ex_valid = 1'b0; @(negedge clk); step();
    mem_fwd_valid = 1'b0;
    push(32'hBB, 32'd1, 32'd0, 32'h604, 11'h001, 5'd1);
    offer(32'h604, 32'd1, 32'h33, 32'd0, 5'd3, 5'd0, 5'd1, 11'h001, 1'b0, 1'b1, 1'b1, 1'b0);
    step(); id_to_ex_valid = 1'b0; @(negedge clk); step();
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd0; wb_fwd_rd = 5'd0;
    push(32'd0, 32'd1, 32'd0, 32'h608, 11'h001, 5'd1);
    offer(32'h608, 32'd1, 32'd0, 32'd0, 5'd0, 5'd0, 5'd1, 11'h001, 1'b0, 1'b1, 1'b1, 1'b0);
    step(); id_to_ex_valid = 1'b0; @(negedge clk); step();
    mem_fwd_valid = 1'b0; wb_fwd_valid = 1'b0;
`else
    // WB hit on rs1 stalls one cycle, then the register-file value is used
    offer(32'h600, 32'h10, 32'h44, 32'd0, 5'd4, 5'd0, 5'd6, 11'h004, 1'b0, 1'b1, 1'b1, 1'b0);
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'hBB;
    step(); id_to_ex_valid = 1'b0;
    @(negedge clk); check("wb_stall", {31'd0, ex_to_mem_valid}, 32'd0);
    step(); wb_fwd_valid = 1'b0;
    push(32'h44, 32'h10, 32'd0, 32'h600, 11'h004, 5'd6);
    @(negedge clk); check("wb_release", {31'd0, ex_to_mem_valid}, 32'd1);
    step();

    // Non-load MEM hit on used rs2 still stalls
    offer(32'h700, 32'd0, 32'd0, 32'h55, 5'd0, 5'd5, 5'd7, 11'h008, 1'b0, 1'b0, 1'b1, 1'b0);
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'hCC;
    step(); id_to_ex_valid = 1'b0;
    @(negedge clk); check("mem_stall", {31'd0, ex_to_mem_valid}, 32'd0);
    step(); mem_fwd_valid = 1'b0;
    push(32'd0, 32'h55, 32'h55, 32'h700, 11'h008, 5'd7);
    @(negedge clk); step();

    // Store consumes rs2 even with immediate src2
    offer(32'h800, 32'h8, 32'h80, 32'h58, 5'd1, 5'd5, 5'd0, 11'h001, 1'b0, 1'b1, 1'b0, 1'b0);
    mem_fwd_valid = 1'b1;
    step(); id_to_ex_valid = 1'b0;
    @(negedge clk); check("store_stall", {31'd0, ex_to_mem_valid}, 32'd0);
    step(); mem_fwd_valid = 1'b0;
    push(32'h80, 32'h8, 32'h58, 32'h800, 11'h001, 5'd0);
    @(negedge clk); step();

    // Same hit on an unused rs2 (ALU-immediate op) does not stall
    push(32'h80, 32'h8, 32'h58, 32'h900, 11'h001, 5'd0);
    offer(32'h900, 32'h8, 32'h80, 32'h58, 5'd1, 5'd5, 5'd0, 11'h001, 1'b0, 1'b1, 1'b1, 1'b0);
    mem_fwd_valid = 1'b1;
    step(); id_to_ex_valid = 1'b0;
    @(negedge clk); check("unused_nostall", {31'd0, ex_to_mem_valid}, 32'd1);
    step(); mem_fwd_valid = 1'b0;

    // x0 never matches a producer
    push(32'd0, 32'd3, 32'd0, 32'hA00, 11'h001, 5'd1);
    offer(32'hA00, 32'd3, 32'd0, 32'd0, 5'd0, 5'd0, 5'd1, 11'h001, 1'b0, 1'b1, 1'b1, 1'b0);
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd0;
    step(); id_to_ex_valid = 1'b0;
    @(negedge clk); check("x0_nostall", {31'd0, ex_to_mem_valid}, 32'd1);
    step(); wb_fwd_valid = 1'b0;
`endif

    repeat (3) step();
    check("sb_drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
